// File: rtl/sar_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sar_scan_ctrl_if                                                |
// | Purpose  : Result stream between the SAR scan sequencer and its consumer:  |
// |            valid/ready handshake carrying a 10-bit result and channel tag. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sar_scan_ctrl_if #(
  parameter int NCH = 4
) ();
  localparam int CHW = $clog2(NCH);

  logic           out_valid;
  logic           out_ready;
  logic [9:0]     out_data;
  logic [CHW-1:0] out_ch;

  // Producer side: the scan sequencer.
  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  // Consumer side: downstream result sink.
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sar_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sar_scan_ctrl                                                   |
// | Purpose  : Multi-channel scan sequencer for the 10-bit sarlogic SAR ADC.   |
// |            Selects the channel, drives en/cal, waits for valid, optionally |
// |            averages 2^AVG_LOG2 conversions per channel and streams tagged  |
// |            results. Calibration is inserted only at scan-pass boundaries.  |
// | Options  : define SAR_SCAN_AVG_EN to compile per-channel averaging; when   |
// |            undefined each channel delivers a single conversion.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sar_scan_ctrl #(
  parameter int NCH           = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CAL_WAIT      = 16,
  parameter int CAL_INTERVAL  = 256,
  parameter int TIMEOUT       = 64,
  parameter int AVG_LOG2      = 2,
  localparam int CHW          = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            continuous,
  input  logic [NCH-1:0]  ch_mask,
  output logic            busy,
  output logic            done,
  output logic            timeout_err,
  output logic [CHW-1:0]  mux_sel,
  output logic            adc_en,
  output logic            adc_cal,
  input  logic            adc_valid,
  input  logic [9:0]      adc_result,
  sar_scan_ctrl_if.master out_if
);

  // Shared wait counter covers settling, calibration wait and CONV timeout.
  localparam int c_CNT_MAX = (TIMEOUT > CAL_WAIT)
                           ? ((TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES)
                           : ((CAL_WAIT > SETTLE_CYCLES) ? CAL_WAIT : SETTLE_CYCLES);
  localparam int c_CNTW = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNTW-1:0] c_SETTLE_LAST = c_CNTW'(SETTLE_CYCLES - 1);
  localparam logic [c_CNTW-1:0] c_CALW_LAST   = c_CNTW'(CAL_WAIT - 1);
  localparam logic [c_CNTW-1:0] c_TO_LAST     = c_CNTW'(TIMEOUT - 1);

  // Conversion counter saturates at CAL_INTERVAL.
  localparam int c_CCW = $clog2(CAL_INTERVAL + 1);
  localparam logic [c_CCW-1:0] c_CONV_SAT = c_CCW'(CAL_INTERVAL);
  localparam logic [c_CCW-1:0] c_CONV_SET = c_CCW'(CAL_INTERVAL - 1);

`ifdef SAR_SCAN_AVG_EN
  localparam int c_ACCW = 10 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] c_NS_LAST = (AVG_LOG2 + 1)'((2 ** AVG_LOG2) - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAL      = 3'd1,
    S_CAL_WAIT = 3'd2,
    S_SETTLE   = 3'd3,
    S_CONV     = 3'd4,
    S_OUT      = 3'd5
`ifdef SAR_SCAN_AVG_EN
    ,
    S_GAP      = 3'd6
`endif
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_terr;
  logic [CHW-1:0]      r_ch;
  logic                r_en;
  logic                r_cal;
  logic                r_ovalid;
  logic [9:0]          r_odata;
  logic [CHW-1:0]      r_och;
  logic [NCH-1:0]      r_mask;
  logic [c_CNTW-1:0]   r_cnt;
  logic [c_CCW-1:0]    r_conv_cnt;
  logic                r_cal_pend;

`ifdef SAR_SCAN_AVG_EN
  logic [c_ACCW-1:0]   r_acc;
  logic [AVG_LOG2:0]   r_nsamp;
  logic [c_ACCW-1:0]   w_acc_sum;
  logic                w_last_sample;

  assign w_acc_sum     = r_acc + c_ACCW'(adc_result);
  assign w_last_sample = (r_nsamp == c_NS_LAST);
`else
  // AVG_LOG2 has no effect without averaging; this empty block only references it.
  if (AVG_LOG2 < 0) begin : g_avg_unused
  end
`endif

  logic           w_first_any;
  logic [CHW-1:0] w_first_ch;
  logic           w_next_any;
  logic [CHW-1:0] w_next_ch;

  // Lowest set bit of the live mask, and next set bit of the latched mask above the current channel.
  always_comb begin
    w_first_any = 1'b0;
    w_first_ch  = '0;
    w_next_any  = 1'b0;
    w_next_ch   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_first_any = 1'b1;
        w_first_ch  = CHW'(i);
      end
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next_any = 1'b1;
        w_next_ch  = CHW'(i);
      end
    end
  end

  // Scan sequencer: state, counters, datapath and every output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_terr     <= 1'b0;
      r_ch       <= '0;
      r_en       <= 1'b0;
      r_cal      <= 1'b0;
      r_ovalid   <= 1'b0;
      r_odata    <= '0;
      r_och      <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_conv_cnt <= '0;
      r_cal_pend <= 1'b1;
`ifdef SAR_SCAN_AVG_EN
      r_acc      <= '0;
      r_nsamp    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_cal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_first_any) begin
            r_mask <= ch_mask;
            r_terr <= 1'b0;
            r_ch   <= w_first_ch;
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (r_cal_pend) begin
              r_state <= S_CAL;
              r_cal   <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
            end
          end
        end

        S_CAL: begin
          r_cnt   <= '0;
          r_state <= S_CAL_WAIT;
        end

        S_CAL_WAIT: begin
          if (r_cnt == c_CALW_LAST) begin
            r_cal_pend <= 1'b0;
            r_conv_cnt <= '0;
            r_cnt      <= '0;
            r_state    <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_state <= S_CONV;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CONV: begin
          if (adc_valid) begin
            r_en  <= 1'b0;
            r_cnt <= '0;
            if (r_conv_cnt != c_CONV_SAT) begin
              r_conv_cnt <= r_conv_cnt + 1'b1;
            end
            if (r_conv_cnt >= c_CONV_SET) begin
              r_cal_pend <= 1'b1;
            end
`ifdef SAR_SCAN_AVG_EN
            r_acc   <= w_acc_sum;
            r_nsamp <= r_nsamp + 1'b1;
            if (w_last_sample) begin
              r_ovalid <= 1'b1;
              r_odata  <= 10'(w_acc_sum >> AVG_LOG2);
              r_och    <= r_ch;
              r_state  <= S_OUT;
            end else begin
              r_state <= S_GAP;
            end
`else
            r_ovalid <= 1'b1;
            r_odata  <= adc_result;
            r_och    <= r_ch;
            r_state  <= S_OUT;
`endif
          end else if (r_cnt == c_TO_LAST) begin
            // Converter never answered: abandon the pass without a result or done.
            r_terr  <= 1'b1;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef SAR_SCAN_AVG_EN
        S_GAP: begin
          r_en    <= 1'b1;
          r_state <= S_CONV;
        end
`endif

        S_OUT: begin
          if (r_ovalid && out_if.out_ready) begin
            r_ovalid <= 1'b0;
            r_cnt    <= '0;
`ifdef SAR_SCAN_AVG_EN
            r_acc    <= '0;
            r_nsamp  <= '0;
`endif
            if (w_next_any) begin
              r_ch    <= w_next_ch;
              r_state <= S_SETTLE;
            end else if (continuous && w_first_any) begin
              // Pass wrap: new mask takes effect here, and so does any pending calibration.
              r_mask <= ch_mask;
              r_ch   <= w_first_ch;
              if (r_cal_pend) begin
                r_state <= S_CAL;
                r_cal   <= 1'b1;
              end else begin
                r_state <= S_SETTLE;
              end
            end else begin
              if (continuous) begin
                r_mask <= ch_mask;
              end
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_en     <= 1'b0;
          r_ovalid <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign timeout_err      = r_terr;
  assign mux_sel          = r_ch;
  assign adc_en           = r_en;
  assign adc_cal          = r_cal;
  assign out_if.out_valid = r_ovalid;
  assign out_if.out_data  = r_odata;
  assign out_if.out_ch    = r_och;

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sar_scan_ctrl                                                |
// | Purpose  : Directed self-checking bench for sar_scan_ctrl with a simple    |
// |            converter model (valid three cycles after en rises).            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sar_scan_ctrl;
  localparam int NCH = 4;

`ifdef SAR_SCAN_AVG_EN
  localparam int NS       = 4;
  localparam int EXP_SP0  = 101;   // (100+101+102+103)>>2
  localparam int EXP_BP   = 201;   // (200+201+202+203)>>2
  localparam int CAL_STEP = 2;     // 8 conversions per pass of two channels
  localparam int N_CALS   = 8;
`else
  localparam int NS       = 1;
  localparam int EXP_SP0  = 100;
  localparam int EXP_BP   = 200;
  localparam int CAL_STEP = 8;     // 2 conversions per pass, cal every 4 passes
  localparam int N_CALS   = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic           continuous = 1'b0;
  logic [3:0]     ch_mask = '0;
  logic           busy, done, timeout_err, adc_en, adc_cal;
  logic [1:0]     mux_sel;
  logic           adc_valid = 1'b0;
  logic [9:0]     adc_result = '0;

  sar_scan_ctrl_if #(.NCH(NCH)) bus ();

  sar_scan_ctrl #(
    .NCH(NCH), .SETTLE_CYCLES(4), .CAL_WAIT(16), .CAL_INTERVAL(8),
    .TIMEOUT(64), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .busy(busy), .done(done), .timeout_err(timeout_err),
    .mux_sel(mux_sel), .adc_en(adc_en), .adc_cal(adc_cal),
    .adc_valid(adc_valid), .adc_result(adc_result), .out_if(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Converter model
  logic [9:0] adc_q[$];
  bit         adc_never = 1'b0;
  int         adc_lat = 0;
  int         adc_valid_cnt = 0;

  always @(negedge clk) begin
    if (adc_en === 1'b1 && !adc_never && !adc_valid) begin
      if (adc_lat == 2) begin
        adc_valid = 1'b1;
        if (adc_q.size() > 0) adc_result = adc_q.pop_front();
        else adc_result = 10'd0;
        adc_valid_cnt++;
        adc_lat = 0;
      end else begin
        adc_lat++;
      end
    end else begin
      adc_valid = 1'b0;
      if (adc_en !== 1'b1) adc_lat = 0;
    end
  end

  // Event monitor
  int cal_cnt = 0, cal_wide = 0, overlap = 0, done_cnt = 0, hs_cnt = 0;
  int cal_hs[$];
  bit cal_prev = 1'b0;

  always @(negedge clk) begin
    if (adc_cal === 1'b1) begin
      cal_cnt++;
      cal_hs.push_back(hs_cnt);
      if (cal_prev) cal_wide++;
    end
    cal_prev = (adc_cal === 1'b1);
    if (adc_cal === 1'b1 && adc_en === 1'b1) overlap++;
    if (done === 1'b1) done_cnt++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] m);
    ch_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_out(output bit ok, output logic [1:0] ch, output logic [9:0] data);
    ok = 1'b0; ch = '0; data = '0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1; ch = bus.out_ch; data = bus.out_data;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (adc_en === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    n_cmp++; if (adc_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", adc_en); end
    n_cmp++; if (adc_cal !== 1'b0) begin n_bad++; $display("FAIL reset_cal: got %b want 0", adc_cal); end
    n_cmp++; if (mux_sel !== 2'd0) begin n_bad++; $display("FAIL reset_mux: got %0d want 0", mux_sel); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 10'd0) begin n_bad++; $display("FAIL reset_odata: got %0d want 0", bus.out_data); end
    n_cmp++; if (bus.out_ch !== 2'd0) begin n_bad++; $display("FAIL reset_och: got %0d want 0", bus.out_ch); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_zero_mask();
    do_start(4'b0000);
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_mask_busy: got %b want 0", busy); end
    n_cmp++; if (cal_cnt !== 0) begin n_bad++; $display("FAIL zero_mask_cal: got %0d want 0", cal_cnt); end
  endtask

  task automatic test_single_pass();
    bit ok; logic [1:0] ch; logic [9:0] d;
    adc_q.delete();
    for (int k = 0; k < NS; k++) adc_q.push_back(10'(100 + k));
    for (int k = 0; k < NS; k++) adc_q.push_back(10'd1023);
    bus.out_ready = 1'b1;
    cal_cnt = 0; done_cnt = 0;
    do_start(4'b0101);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sp_busy: got %b want 1", busy); end
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd0 || d !== 10'(EXP_SP0)) begin n_bad++; $display("FAIL sp_out0: got ok=%0d ch=%0d data=%0d want ch=0 data=%0d", ok, ch, d, EXP_SP0); end
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd2 || d !== 10'd1023) begin n_bad++; $display("FAIL sp_out1: got ok=%0d ch=%0d data=%0d want ch=2 data=1023", ok, ch, d); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sp_idle: busy=%b want 0", busy); end
    tick();
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL sp_done: got %0d want 1", done_cnt); end
    n_cmp++; if (cal_cnt !== 1) begin n_bad++; $display("FAIL sp_cal: got %0d want 1", cal_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok; logic [1:0] ch; logic [9:0] d;
    int drop = 0, dchg = 0, cchg = 0, en_hi = 0;
    adc_q.delete();
    for (int k = 0; k < NS; k++) adc_q.push_back(10'(200 + k));
    bus.out_ready = 1'b0;
    done_cnt = 0;
    do_start(4'b0001);
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd0 || d !== 10'(EXP_BP)) begin n_bad++; $display("FAIL bp_out: got ok=%0d ch=%0d data=%0d want ch=0 data=%0d", ok, ch, d, EXP_BP); end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin ch_mask = 4'b1000; start = 1'b1; end
      tick();
      start = 1'b0;
      if (bus.out_valid !== 1'b1) drop++;
      if (bus.out_data !== d) dchg++;
      if (bus.out_ch !== ch) cchg++;
      if (adc_en !== 1'b0) en_hi++;
    end
    n_cmp++; if (drop !== 0) begin n_bad++; $display("FAIL bp_valid_held: got %0d drops want 0", drop); end
    n_cmp++; if (dchg !== 0) begin n_bad++; $display("FAIL bp_data_stable: got %0d changes want 0", dchg); end
    n_cmp++; if (cchg !== 0) begin n_bad++; $display("FAIL bp_ch_stable: got %0d changes want 0", cchg); end
    n_cmp++; if (en_hi !== 0) begin n_bad++; $display("FAIL bp_no_en: got %0d cycles want 0", en_hi); end
    bus.out_ready = 1'b1;
    wait_idle(ok);
    tick(); tick();
    n_cmp++; if (!ok || busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle: busy=%b want 0", busy); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    bit ok; int en_cycles = 0;
    adc_q.delete();
    adc_never = 1'b1;
    bus.out_ready = 1'b1;
    done_cnt = 0;
    do_start(4'b0010);
    wait_en(ok);
    if (ok) en_cycles = 1;
    for (int i = 0; i < 200 && ok; i++) begin
      tick();
      if (adc_en === 1'b1) en_cycles++;
      else break;
    end
    n_cmp++; if (en_cycles !== 64) begin n_bad++; $display("FAIL to_conv_cycles: got %0d want 64", en_cycles); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", timeout_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: busy=%b want 0", busy); end
    tick();
    n_cmp++; if (done_cnt !== 0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL to_no_done: done=%0d ovalid=%b want 0 0", done_cnt, bus.out_valid); end
    adc_never = 1'b0;
    do_start(4'b0010);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    wait_idle(ok);
    n_cmp++; if (!ok || timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_recover: ok=%0d terr=%b want 1 0", ok, timeout_err); end
  endtask

  task automatic test_continuous_cal();
    bit ok; bit reached = 1'b0;
    rstn = 1'b0; tick(); tick(); rstn = 1'b1;
    adc_q.delete();
    cal_hs.delete(); hs_cnt = 0; cal_cnt = 0; done_cnt = 0;
    bus.out_ready = 1'b1;
    continuous = 1'b1;
    do_start(4'b0011);
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (hs_cnt >= 15) begin reached = 1'b1; break; end
    end
    continuous = 1'b0;
    wait_idle(ok);
    tick();
    n_cmp++; if (!reached || !ok || hs_cnt !== 16) begin n_bad++; $display("FAIL cont_outputs: got %0d want 16", hs_cnt); end
    n_cmp++; if (cal_hs.size() !== N_CALS) begin n_bad++; $display("FAIL cont_cal_count: got %0d want %0d", cal_hs.size(), N_CALS); end
    for (int k = 0; k < cal_hs.size() && k < N_CALS; k++) begin
      n_cmp++;
      if (cal_hs[k] !== k * CAL_STEP) begin n_bad++; $display("FAIL cont_cal_pos%0d: after %0d outputs want %0d", k, cal_hs[k], k * CAL_STEP); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL cont_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_mid_scan();
    bit ok; logic [1:0] ch; logic [9:0] d;
    adc_q.delete();
    bus.out_ready = 1'b1;
    done_cnt = 0;
    continuous = 1'b1;
    do_start(4'b0011);
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd0) begin n_bad++; $display("FAIL mid_ch_a: got ok=%0d ch=%0d want 0", ok, ch); end
    ch_mask = 4'b0100;
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd1) begin n_bad++; $display("FAIL mid_ch_b: got ok=%0d ch=%0d want 1", ok, ch); end
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd2) begin n_bad++; $display("FAIL mid_ch_c: got ok=%0d ch=%0d want 2", ok, ch); end
    ch_mask = 4'b0000;
    wait_idle(ok);
    tick();
    n_cmp++; if (!ok || done_cnt !== 1) begin n_bad++; $display("FAIL mid_zero_wrap: ok=%0d done=%0d want 1 1", ok, done_cnt); end
    continuous = 1'b0;
    // Reset asserted for one cycle while converting.
    do_start(4'b0001);
    wait_en(ok);
    rstn = 1'b0;
    tick();
    n_cmp++; if (!ok || adc_en !== 1'b0 || busy !== 1'b0 || adc_cal !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl: en=%b busy=%b cal=%b want 0 0 0", adc_en, busy, adc_cal); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 10'd0 || bus.out_ch !== 2'd0) begin n_bad++; $display("FAIL rst_out: valid=%b data=%0d ch=%0d want 0 0 0", bus.out_valid, bus.out_data, bus.out_ch); end
    n_cmp++; if (mux_sel !== 2'd0 || done !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_misc: mux=%0d done=%b terr=%b want 0 0 0", mux_sel, done, timeout_err); end
    rstn = 1'b1;
    do_start(4'b0001);
    n_cmp++; if (adc_cal !== 1'b1) begin n_bad++; $display("FAIL rst_cal_first: got %b want 1", adc_cal); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_finish: busy=%b want 0", busy); end
  endtask

  task automatic test_single_ch3();
    bit ok; logic [1:0] ch; logic [9:0] d;
    adc_q.delete();
    for (int k = 0; k < NS; k++) adc_q.push_back(10'd512);
    bus.out_ready = 1'b1;
    adc_valid_cnt = 0;
    do_start(4'b1000);
    wait_out(ok, ch, d);
    n_cmp++; if (!ok || ch !== 2'd3 || d !== 10'd512) begin n_bad++; $display("FAIL ch3_out: got ok=%0d ch=%0d data=%0d want ch=3 data=512", ok, ch, d); end
    wait_idle(ok);
    tick(); tick();
    n_cmp++; if (!ok || adc_valid_cnt !== NS) begin n_bad++; $display("FAIL ch3_valids: got %0d want %0d", adc_valid_cnt, NS); end
    n_cmp++; if (cal_wide !== 0 || overlap !== 0) begin n_bad++; $display("FAIL cal_shape: wide=%0d overlap=%0d want 0 0", cal_wide, overlap); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_zero_mask();
    test_single_pass();
    test_backpressure();
    test_timeout();
    test_continuous_cal();
    test_mid_scan();
    test_single_ch3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
`default_nettype wire
